// File: rtl/nibble_serializer_pkg.sv
// Shared types and constants for the nibble serializer: FSM states, line levels, default width.
package nibble_serializer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;
    localparam int   DATA_W_DEFAULT = 4;

endpackage

// File: rtl/nibble_serializer_baud_tick.sv
// Bit-period timer: one-cycle tick every BAUD_DIV enabled cycles; count clears while disabled.
module baud_tick
    import nibble_serializer_pkg::*;
#(
    parameter int BAUD_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nibble_serializer.sv
// UART-style word serializer: start, DATA_W bits LSB first, stop; each bit held BAUD_DIV cycles.
// Define PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module nibble_serializer
    import nibble_serializer_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int BAUD_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              load,
    output logic              ready,
    output logic              busy,
    output logic              ser_out,
    output logic              done
);

    generate
        if (BAUD_DIV < 1) begin : g_bad_baud_div
            $error("nibble_serializer: BAUD_DIV must be >= 1");
        end
    endgenerate

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              ser_nxt;
    logic              tick;
    logic              last_bit;

    assign ready    = (state == IDLE);
    assign busy     = !ready;
    assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

    baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .tick (tick)
    );

`ifdef PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic par_q;

    // Parity is taken from the word as captured, so later input changes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (state == IDLE && load) begin
            par_q <= ^data;
        end
    end
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt   = START;
                    shreg_nxt   = data;
                    bit_cnt_nxt = '0;
                end
            end
            START:  if (tick) state_nxt = DATA;
            DATA: begin
                if (tick) begin
                    if (last_bit) begin
                        state_nxt = AFTER_DATA;
                    end else begin
                        shreg_nxt   = shreg >> 1;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: if (tick) state_nxt = STOP;
            STOP:   if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Line level is decoded from the upcoming state so ser_out comes straight from a flop.
    always_comb begin
        ser_nxt = STOP_BIT;
        case (state_nxt)
            START: ser_nxt = START_BIT;
            DATA:  ser_nxt = shreg_nxt[0];
`ifdef PARITY_EN
            PARITY: ser_nxt = par_q;
`endif
            default: ser_nxt = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            ser_out <= STOP_BIT;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            ser_out <= ser_nxt;
            done    <= (state == STOP) && tick;
        end
    end

endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: vector table, directed corner sequences, random traffic vs a queue model.
module tb_nibble_serializer;

`ifdef PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL = 6 + PB;

    typedef bit bq_t[$];
    typedef struct {
        logic [3:0] word;
        logic [7:0] seq;
        int         len;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       load1 = 1'b0;
    logic       load3 = 1'b0;
    logic [3:0] data1 = 4'h0;
    logic [3:0] data3 = 4'h0;
    logic       ready1, busy1, ser1, done1;
    logic       ready3, busy3, ser3, done3;
    int         vecs = 0;
    int         miss = 0;

    always #5 clk = ~clk;

    nibble_serializer #(.DATA_W(4), .BAUD_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .data(data1), .load(load1),
        .ready(ready1), .busy(busy1), .ser_out(ser1), .done(done1)
    );

    nibble_serializer #(.DATA_W(4), .BAUD_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .data(data3), .load(load3),
        .ready(ready3), .busy(busy3), .ser_out(ser3), .done(done3)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_n(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected line level for every cycle of one frame.
    function automatic bq_t frame_bits(input logic [3:0] w, input int div);
        bq_t q;
        bit  b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 4; i++) b.push_back(w[i]);
        if (PB == 1) b.push_back(^w);
        b.push_back(1'b1);
        foreach (b[i]) for (int r = 0; r < div; r++) q.push_back(b[i]);
        return q;
    endfunction

    bq_t exp1, exp3;
    bit  dexp1 = 1'b0;
    bit  dexp3 = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp1.delete();
            exp3.delete();
            dexp1 = 1'b0;
            dexp3 = 1'b0;
        end else begin
            dexp1 = (exp1.size() == 1);
            if (exp1.size() != 0) void'(exp1.pop_front());
            else if (load1) exp1 = frame_bits(data1, 1);
            dexp3 = (exp3.size() == 1);
            if (exp3.size() != 0) void'(exp3.pop_front());
            else if (load3) exp3 = frame_bits(data3, 3);
        end
    end

    always @(negedge clk) begin
        chk("sb1_ser",   ser1,   (exp1.size() != 0) ? exp1[0] : 1'b1);
        chk("sb1_ready", ready1, exp1.size() == 0);
        chk("sb1_busy",  busy1,  exp1.size() != 0);
        chk("sb1_done",  done1,  dexp1);
        chk("sb3_ser",   ser3,   (exp3.size() != 0) ? exp3[0] : 1'b1);
        chk("sb3_ready", ready3, exp3.size() == 0);
        chk("sb3_busy",  busy3,  exp3.size() != 0);
        chk("sb3_done",  done3,  dexp3);
    end

    // Called just after a falling edge; returns just after the falling edge of the Done cycle.
    task automatic apply_frame(input logic [3:0] w, input logic [7:0] seq, input int len, input bit noise);
        int n = 0;
        while (!ready1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", ready1, 1'b1);
        data1 = w;
        load1 = 1'b1;
        @(posedge clk);
        #1;
        load1 = 1'b0;
        data1 = ~w;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            chk("frame_ser", ser1, seq[len-1-k]);
            chk("frame_busy", busy1, 1'b1);
            if (noise) begin
                load1 = (k == 1 || k == 3);
                data1 = 4'h0;
            end
        end
        @(negedge clk);
        chk("frame_done", done1, 1'b1);
        chk("frame_ready", ready1, 1'b1);
        chk("frame_idle_ser", ser1, 1'b1);
    endtask

    initial begin
        vec_t tbl[6];
        int   n;
`ifdef PARITY_EN
        tbl[0] = '{4'b1010, 8'b0010101, 7};
        tbl[1] = '{4'b1011, 8'b0110111, 7};
        tbl[2] = '{4'b0000, 8'b0000001, 7};
        tbl[3] = '{4'b1111, 8'b0111101, 7};
        tbl[4] = '{4'b0110, 8'b0011001, 7};
        tbl[5] = '{4'b0101, 8'b0101001, 7};
`else
        tbl[0] = '{4'b1010, 8'b001011, 6};
        tbl[1] = '{4'b1011, 8'b011011, 6};
        tbl[2] = '{4'b0000, 8'b000001, 6};
        tbl[3] = '{4'b1111, 8'b011111, 6};
        tbl[4] = '{4'b0110, 8'b001101, 6};
        tbl[5] = '{4'b0101, 8'b010101, 6};
`endif
        repeat (2) @(negedge clk);
        chk("rst_ser", ser1, 1'b1);
        chk("rst_ready", ready1, 1'b1);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Consecutive table entries also load in the Done cycle of the previous frame.
        for (int i = 0; i < 6; i++) apply_frame(tbl[i].word, tbl[i].seq, tbl[i].len, 1'b0);

        data3 = 4'b0001;
        load3 = 1'b1;
        @(posedge clk);
        #1;
        load3 = 1'b0;
        data3 = 4'b1110;
        for (int c = 1; c <= 3 * FL; c++) begin
            @(negedge clk);
            chk("div3_ser", ser3, !((c <= 3) || (c >= 7 && c <= 15)));
            chk("div3_busy", busy3, 1'b1);
        end
        @(negedge clk);
        chk("div3_done", done3, 1'b1);
        chk("div3_ready", ready3, 1'b1);

        data1 = 4'hF;
        load1 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            @(negedge clk);
            chk("b2b_start", busy1, 1'b1);
            n = 1;
            while (busy1 && n < 100) begin
                @(negedge clk);
                if (busy1) n++;
            end
            chk_n("b2b_len", n, FL);
            chk("b2b_gap_done", done1, 1'b1);
            chk("b2b_gap_ser", ser1, 1'b1);
        end
        load1 = 1'b0;

        apply_frame(tbl[3].word, tbl[3].seq, tbl[3].len, 1'b1);

        data1 = 4'b1010;
        load1 = 1'b1;
        @(posedge clk);
        #1;
        load1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_ser", ser1, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_ser", ser1, 1'b1);
        chk("mid_rst_ready", ready1, 1'b1);
        chk("mid_rst_busy", busy1, 1'b0);
        chk("mid_rst_done", done1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", done1, 1'b0);
        end
        apply_frame(tbl[5].word, tbl[5].seq, tbl[5].len, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #2;
            load1 = ($urandom_range(0, 3) == 0);
            data1 = 4'($urandom);
            load3 = ($urandom_range(0, 3) == 0);
            data3 = 4'($urandom);
            rst   = ($urandom_range(0, 249) == 0);
        end
        @(negedge clk);
        #2;
        rst   = 1'b0;
        load1 = 1'b0;
        load3 = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/nibble_serializer.md
NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 Parameter DATA_W, default 4, parallel word width in bits.
REQ-002 Parameter BAUD_DIV, default 1, clock cycles per serial bit; SHALL be >= 1, with an elaboration-time error otherwise.
REQ-003 Clk  input  1  sole clock, rising-edge active.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Input  input  DATA_W  parallel word to transmit.
REQ-006 Load  input  1  request to capture Input and start a frame.
REQ-007 Ready  output  1  high when a Load will be accepted.
REQ-008 Busy  output  1  high while a frame is on the line.
REQ-009 SerOut  output  1  serial line, idle high.
REQ-010 Done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-011 Frame order SHALL be: start bit (0), DATA_W data bits LSB first, optional parity bit (REQ-024), stop bit (1).
REQ-012 Each bit SHALL be held on SerOut for exactly BAUD_DIV cycles.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 Transitions: IDLE->START on Load&&Ready; START->DATA; DATA->DATA until DATA_W bits have been sent; DATA->PARITY (if enabled) or STOP; PARITY->STOP; STOP->IDLE. Every transition except IDLE->START occurs on bit-period expiry.
REQ-015 Ready SHALL be 1 only in IDLE; Busy SHALL equal !Ready.
REQ-016 Input SHALL be captured into an internal shift register on the Clk edge where Load&&Ready; SerOut SHALL be 0 from the next cycle.
REQ-017 Load while Busy SHALL be ignored, with no effect on the current frame and no queuing.
REQ-018 Changes on Input after capture SHALL NOT affect the frame in flight.
REQ-019 Done SHALL be registered and high for exactly the one cycle in which the FSM has returned to IDLE after STOP.
REQ-020 Back-to-back frames: a Load asserted in the cycle Done is high SHALL be accepted, so the line idles for exactly one cycle between frames.
REQ-021 SerOut SHALL be registered and glitch-free; it SHALL be 1 in IDLE and STOP.

Reset
REQ-022 Reset assertion SHALL asynchronously force: state IDLE, SerOut=1, Ready=1, Busy=0, Done=0, bit counter=0, baud counter=0, shift register=0.
REQ-023 Reset mid-frame SHALL abort the frame immediately with no stop bit emitted; the first Load after reset deassertion SHALL start a clean frame.

Configuration
REQ-024 With PARITY_EN defined, the PARITY state SHALL transmit the even-parity bit (XOR of the captured word) between the last data bit and the stop bit, giving a frame of DATA_W+3 bits.
REQ-025 Without PARITY_EN, the PARITY state SHALL be unreachable and the frame SHALL be DATA_W+2 bits.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef, the START_BIT=0 and STOP_BIT=1 constants, and the DATA_W default.
REQ-027 The baud-period counter SHALL be a separate sub-module, baud_tick, which outputs a one-cycle tick every BAUD_DIV cycles while enabled and clears when disabled.

Verification
REQ-028 BAUD_DIV=1, no parity, Input=4'b1010, pulse Load -> SerOut=0,0,1,0,1,1 over the next 6 cycles; Done high on cycle 7; Ready high on cycle 7.
REQ-029 PARITY_EN, BAUD_DIV=1, Input=4'b1011 -> SerOut=0,1,1,0,1,1,1 (parity=1); Input=4'b1010 -> SerOut=0,0,1,0,1,0,1.
REQ-030 BAUD_DIV=3, Input=4'b0001 -> each bit held 3 cycles; frame is 18 cycles; SerOut is low for cycles 1-3, high for 4-6, and low for 7-15.
REQ-031 Load held high continuously with Input=4'hF -> frames repeat separated by exactly one idle cycle; Load pulses mid-frame with Input=4'h0 -> frame content unchanged.
REQ-032 Reset asserted during the third data bit -> SerOut=1, Ready=1, Busy=0 in the same cycle with no Done pulse; the next Load with Input=4'h5 -> correct full frame.
